vga_fb_arbiter: RTL



---
 rtl/vga_fb_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer arbiter between VGA scan-out and a pixel writer
//
// Purpose: owns the 160x120x12-bit framebuffer RAM. One display read is
// scheduled every 4 pixel clocks of active video; all other cycles are free
// for the writer. Read pixels are 4x4 upscaled onto the 640x480 window.
//
// Ports:
//   clk, rst_n                  pixel clock, asynchronous active-low reset
//   H_count_value/V_count_value h/v position from the timing counters
//   disp_en                     display enable, sampled at h=0,v=0
//   wr_req/wr_addr/wr_data      writer request, held until wr_ack
//   wr_ack/wr_err               one-cycle consume pulse / out-of-range flag
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   registered RAM port
//   Red/Green/Blue              registered pixel outputs
//   frame_start                 pulse in the cycle after h=0,v=0
module vga_fb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] H_count_value,
    input  logic [15:0] V_count_value,
    input  logic        disp_en,
    input  logic        wr_req,
    input  logic [14:0] wr_addr,
    input  logic [11:0] wr_data,
    output logic        wr_ack,
    output logic        wr_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [11:0] mem_wdata,
    input  logic [11:0] mem_rdata,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue,
    output logic        frame_start
);

    localparam logic [15:0] V_FIRST   = 16'd35;
    localparam logic [15:0] V_LAST    = 16'd514;
    localparam logic [15:0] SLOT_H0   = 16'd141;
    localparam logic [15:0] SLOT_HLST = 16'd777;
    localparam logic [15:0] H_LAST    = 16'd783;
    localparam logic [14:0] FB_WORDS  = 15'd19200;

    logic        disp_q;
    logic [1:0]  rd_pipe;     // display slot delayed by 1 and 2 clocks
    logic        v_active;
    logic        disp_slot;
    logic        frame_edge;
    logic        clear_rgb;
    logic [15:0] v_off;
    logic [15:0] h_off;
    logic [6:0]  row;
    logic [7:0]  col;
    logic [14:0] disp_addr;

    assign v_active   = (V_count_value >= V_FIRST) && (V_count_value <= V_LAST);
    assign frame_edge = (H_count_value == 16'd0) && (V_count_value == 16'd0);

    // Slots sit at h = 141 + 4x; 141 mod 4 == 1, hence the low-bit match.
    assign disp_slot = disp_q && v_active
                     && (H_count_value >= SLOT_H0) && (H_count_value <= SLOT_HLST)
                     && (H_count_value[1:0] == 2'b01);

    // row*160 built as row*128 + row*32; both offsets are only meaningful
    // inside the slot window, where they stay within 0..119 and 0..159.
    assign v_off     = V_count_value - V_FIRST;
    assign h_off     = H_count_value - SLOT_H0;
    assign row       = 7'(v_off >> 2);
    assign col       = 8'(h_off >> 2);
    assign disp_addr = {1'b0, row, 7'b0} + {3'b0, row, 5'b0} + {7'b0, col};

    assign clear_rgb = (H_count_value == H_LAST) || !v_active || !disp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q      <= 1'b0;
            frame_start <= 1'b0;
            rd_pipe     <= 2'b00;
        end else begin
            frame_start <= frame_edge;
            rd_pipe     <= {rd_pipe[0], disp_slot};
            if (frame_edge) begin
                disp_q <= disp_en;
            end
        end
    end

    // RAM port and writer handshake. A display slot always owns the RAM;
    // the writer simply sees its request taken one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 15'd0;
            mem_wdata <= 12'd0;
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
            if (disp_slot) begin
                mem_en   <= 1'b1;
                mem_addr <= disp_addr;
            end else if (wr_req) begin
                wr_ack <= 1'b1;
                if (wr_addr < FB_WORDS) begin
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_addr  <= wr_addr;
                    mem_wdata <= wr_data;
                end else begin
                    wr_err <= 1'b1;
                end
            end
        end
    end

    // Read data arrives two clocks after the slot; capturing then puts
    // pixel x on screen for h = 144+4x .. 147+4x.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Red   <= 4'd0;
            Green <= 4'd0;
            Blue  <= 4'd0;
        end else if (clear_rgb) begin
            Red   <= 4'd0;
            Green <= 4'd0;
            Blue  <= 4'd0;
        end else if (rd_pipe[1]) begin
            Red   <= mem_rdata[11:8];
            Green <= mem_rdata[7:4];
            Blue  <= mem_rdata[3:0];
        end
    end

endmodule
